// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter that hands a shared FIFO read port to one requester at a
// time, delivering up to BURST_LEN words per grant.
module fifo_rd_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_BITS = 16,
   parameter int unsigned BURST_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   cons_ready,
   input  logic                 fifo_valid,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 fifo_rd,
   output logic [NUM_REQ-1:0]   grant,
   output logic [DATA_BITS-1:0] out_data,
   output logic [NUM_REQ-1:0]   out_valid,
   output logic [NUM_REQ-1:0]   done,
   output logic                 busy
);

   localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_BURST  = 1'b1;
   localparam logic [7:0]  LAST_CNT = 8'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_REQ - 1);

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] w_grant_nxt;
   logic [IDX_W-1:0]   r_gidx;
   logic [IDX_W-1:0]   w_gidx_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   w_rr_ptr_nxt;
   logic [7:0]         r_count;
   logic [7:0]         w_count_nxt;
   logic               w_xfer;
   logic               w_end;
   logic               w_found;
   logic [IDX_W-1:0]   w_pick;
   logic [31:0]        w_idx;

   // First set request searching upward from the round-robin pointer, with wrap.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_idx = (32'(r_rr_ptr) + i) % NUM_REQ;
         if (!w_found && req[IDX_W'(w_idx)]) begin
            w_found = 1'b1;
            w_pick  = IDX_W'(w_idx);
         end
      end
   end

   // Next-state, grant bookkeeping and transfer qualification.
   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_gidx_nxt   = r_gidx;
      w_rr_ptr_nxt = r_rr_ptr;
      w_count_nxt  = r_count;
      w_xfer       = 1'b0;
      w_end        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_BURST;
               w_grant_nxt = NUM_REQ'(1) << w_pick;
               w_gidx_nxt  = w_pick;
               w_count_nxt = '0;
            end
         end
         S_BURST: begin
            // Dropping req ends the grant with no transfer in that cycle.
            w_xfer = fifo_valid & cons_ready[r_gidx] & req[r_gidx];
            w_end  = ~req[r_gidx] | (w_xfer & (r_count == LAST_CNT));
            if (w_xfer) begin
               w_count_nxt = r_count + 8'd1;
            end
            if (w_end) begin
               w_state_nxt  = S_IDLE;
               w_grant_nxt  = '0;
               w_rr_ptr_nxt = (r_gidx == MAX_IDX) ? '0 : r_gidx + IDX_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_gidx   <= '0;
         r_rr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_gidx   <= w_gidx_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Pop/strobe/done follow the same-cycle FIFO handshake; reset forces IDLE so they drop at once.
   assign fifo_rd   = w_xfer;
   assign grant     = r_grant;
   assign out_data  = fifo_data;
   assign out_valid = w_xfer ? r_grant : '0;
   assign done      = w_end ? r_grant : '0;
   assign busy      = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus randomized traffic, all
// checked against a grant/word-count reference model.
module tb_fifo_rd_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int BL = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NR-1:0] req = '0;
   logic [NR-1:0] cons_ready = '0;
   logic          fifo_valid = 1'b0;
   logic [DW-1:0] fifo_data = '0;

   logic          fifo_rd, busy;
   logic [NR-1:0] grant, out_valid, done;
   logic [DW-1:0] out_data;
   logic          fifo_rd_b, busy_b;
   logic [NR-1:0] grant_b, out_valid_b, done_b;
   logic [DW-1:0] out_data_b;

   int checks = 0;
   int failures = 0;

   // Reference model: who owns the port, how many words so far, where the next search starts.
   bit         m_busy;
   logic [1:0] m_owner;
   logic [1:0] m_next;
   int         m_words;

   logic [NR-1:0] o_grant, o_done, o_ov;
   logic          o_rd;

   fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_BITS(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .cons_ready(cons_ready),
      .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
      .grant(grant), .out_data(out_data), .out_valid(out_valid),
      .done(done), .busy(busy));

   fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_BITS(DW), .BURST_LEN(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .cons_ready(cons_ready),
      .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_rd(fifo_rd_b),
      .grant(grant_b), .out_data(out_data_b), .out_valid(out_valid_b),
      .done(done_b), .busy(busy_b));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 2'd0;
      m_next  = 2'd0;
      m_words = 0;
   endtask

   // One clock cycle: compare DUT outputs to the model, then advance the model at the edge.
   // Entered and left at a falling edge with inputs already applied.
   task automatic tick();
      logic [NR-1:0] eg, ed, eov;
      logic          ex, ee, found;
      logic [1:0]    c;
      fifo_data = DW'($urandom);
      #1;
      eg  = m_busy ? NR'(1 << m_owner) : '0;
      ex  = m_busy && fifo_valid && cons_ready[m_owner] && req[m_owner];
      ee  = m_busy && (!req[m_owner] || (ex && (m_words + 1 == BL)));
      ed  = ee ? eg : '0;
      eov = ex ? eg : '0;
      o_grant = grant; o_done = done; o_ov = out_valid; o_rd = fifo_rd;
      checks++;
      if (grant !== eg) begin
         failures++; $display("FAIL model_grant t=%0t got=%b exp=%b", $time, grant, eg);
      end
      checks++;
      if (busy !== m_busy) begin
         failures++; $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
      checks++;
      if (fifo_rd !== ex) begin
         failures++; $display("FAIL model_fifo_rd t=%0t got=%b exp=%b", $time, fifo_rd, ex);
      end
      checks++;
      if (out_valid !== eov) begin
         failures++; $display("FAIL model_out_valid t=%0t got=%b exp=%b", $time, out_valid, eov);
      end
      checks++;
      if (done !== ed) begin
         failures++; $display("FAIL model_done t=%0t got=%b exp=%b", $time, done, ed);
      end
      checks++;
      if (out_data !== fifo_data) begin
         failures++; $display("FAIL model_out_data t=%0t got=%h exp=%h", $time, out_data, fifo_data);
      end
      @(posedge clk);
      if (!m_busy) begin
         found = 1'b0;
         for (int k = 0; k < NR; k++) begin
            c = m_next + 2'(k);
            if (!found && req[c]) begin
               found   = 1'b1;
               m_owner = c;
            end
         end
         if (found) begin
            m_busy  = 1'b1;
            m_words = 0;
         end
      end else begin
         if (ex) m_words++;
         if (ee) begin
            m_busy = 1'b0;
            m_next = m_owner + 2'd1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '1; cons_ready = '1; fifo_valid = 1'b1;
      #1;
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
         failures++; $display("FAIL reset_state grant=%b busy=%b exp grant=0000 busy=0", grant, busy);
      end
      checks++;
      if (fifo_rd !== 1'b0 || out_valid !== '0 || done !== '0) begin
         failures++; $display("FAIL reset_outputs rd=%b ov=%b done=%b exp 0/0000/0000", fifo_rd, out_valid, done);
      end
      checks++;
      if (grant_b !== '0 || fifo_rd_b !== 1'b0) begin
         failures++; $display("FAIL reset_state_b grant=%b rd=%b exp 0000/0", grant_b, fifo_rd_b);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001; cons_ready = '1; fifo_valid = 1'b1;
      tick();
      checks++;
      if (o_grant !== 4'b0000) begin
         failures++; $display("FAIL single_idle got=%b exp=0000", o_grant);
      end
      for (int i = 0; i < BL; i++) begin
         tick();
         checks++;
         if (o_grant !== 4'b0001 || o_rd !== 1'b1 || o_done !== ((i == BL - 1) ? 4'b0001 : 4'b0000)) begin
            failures++;
            $display("FAIL single_word%0d grant=%b rd=%b done=%b", i, o_grant, o_rd, o_done);
         end
      end
      tick();
      checks++;
      if (o_grant !== 4'b0000 || o_rd !== 1'b0) begin
         failures++; $display("FAIL single_gap grant=%b rd=%b exp 0000/0", o_grant, o_rd);
      end
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] eg;
      do_reset();
      req = 4'b1111; cons_ready = '1; fifo_valid = 1'b1;
      for (int g = 0; g < 5; g++) begin
         eg = NR'(1 << (g % NR));
         tick();
         checks++;
         if (o_grant !== 4'b0000) begin
            failures++; $display("FAIL rr_gap%0d got=%b exp=0000", g, o_grant);
         end
         for (int i = 0; i < BL; i++) begin
            tick();
            checks++;
            if (o_grant !== eg || o_rd !== 1'b1 || o_done !== ((i == BL - 1) ? eg : 4'b0000)) begin
               failures++;
               $display("FAIL rr_grant%0d_word%0d grant=%b exp=%b rd=%b done=%b", g, i, o_grant, eg, o_rd, o_done);
            end
         end
      end
   endtask

   task automatic test_fifo_stall();
      int words;
      do_reset();
      req = 4'b0010; cons_ready = '1; fifo_valid = 1'b1;
      tick();
      words = 0;
      for (int i = 0; i < 13; i++) begin
         fifo_valid = (i < 3 || i >= 8);
         tick();
         if (o_rd) words++;
         checks++;
         if (o_grant !== 4'b0010 || o_rd !== fifo_valid) begin
            failures++; $display("FAIL stall_cycle%0d grant=%b rd=%b exp 0010/%b", i, o_grant, o_rd, fifo_valid);
         end
         checks++;
         if (o_done !== ((i == 12) ? 4'b0010 : 4'b0000)) begin
            failures++; $display("FAIL stall_done%0d got=%b", i, o_done);
         end
      end
      checks++;
      if (words != BL) begin
         failures++; $display("FAIL stall_words got=%0d exp=%0d", words, BL);
      end
      tick();
      checks++;
      if (o_grant !== 4'b0000) begin
         failures++; $display("FAIL stall_gap got=%b exp=0000", o_grant);
      end
   endtask

   task automatic test_abort();
      do_reset();
      req = 4'b0100; cons_ready = '1; fifo_valid = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      req = 4'b1011;
      tick();
      checks++;
      if (o_rd !== 1'b0 || o_ov !== 4'b0000 || o_done !== 4'b0100) begin
         failures++; $display("FAIL abort_cycle rd=%b ov=%b done=%b exp 0/0000/0100", o_rd, o_ov, o_done);
      end
      tick();
      checks++;
      if (o_grant !== 4'b0000) begin
         failures++; $display("FAIL abort_gap got=%b exp=0000", o_grant);
      end
      tick();
      checks++;
      if (o_grant !== 4'b1000) begin
         failures++; $display("FAIL abort_next got=%b exp=1000", o_grant);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0110; cons_ready = '1; fifo_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (grant !== 4'b0010) begin
         failures++; $display("FAIL midrst_pre grant=%b exp=0010", grant);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== 4'b0000 || fifo_rd !== 1'b0 || done !== 4'b0000 || busy !== 1'b0 || out_valid !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_now grant=%b rd=%b done=%b busy=%b ov=%b", grant, fifo_rd, done, busy, out_valid);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1111;
      tick();
      checks++;
      if (o_grant !== 4'b0000) begin
         failures++; $display("FAIL midrst_idle got=%b exp=0000", o_grant);
      end
      tick();
      checks++;
      if (o_grant !== 4'b0001) begin
         failures++; $display("FAIL midrst_first got=%b exp=0001", o_grant);
      end
   endtask

   task automatic test_burst1();
      logic [NR-1:0] eg;
      do_reset();
      req = 4'b0011; cons_ready = '1; fifo_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         eg = (k % 2 == 0) ? 4'b0000 : ((((k - 1) / 2) % 2 == 0) ? 4'b0001 : 4'b0010);
         checks++;
         if (grant_b !== eg || fifo_rd_b !== (eg != 0) || done_b !== eg || out_valid_b !== eg) begin
            failures++;
            $display("FAIL burst1_cycle%0d grant=%b rd=%b done=%b ov=%b exp grant=%b", k, grant_b, fifo_rd_b, done_b, out_valid_b, eg);
         end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      req = 4'($urandom);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) req = 4'($urandom);
         fifo_valid = ($urandom_range(3) != 0);
         cons_ready = 4'($urandom) | 4'($urandom);
         tick();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_fifo_stall();
      test_abort();
      test_reset_mid();
      test_burst1();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 16, giving the FIFO word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 8, giving the maximum words per grant (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester request level.
REQ-007 The block SHALL have port cons_ready, input, NUM_REQ bits: per-requester ready to accept a word.
REQ-008 The block SHALL have port fifo_valid, input, 1 bit: FIFO non-empty; combinational from the FIFO read side.
REQ-009 The block SHALL have port fifo_data, input, DATA_BITS bits: FIFO head word, valid while fifo_valid=1.
REQ-010 The block SHALL have port fifo_rd, output, 1 bit: pop the FIFO head at this clock edge.
REQ-011 The block SHALL have port grant, output, NUM_REQ bits: registered one-hot grant, all-zero when idle.
REQ-012 The block SHALL have port out_data, output, DATA_BITS bits: word delivered to the granted requester.
REQ-013 The block SHALL have port out_valid, output, NUM_REQ bits: per-requester word strobe.
REQ-014 The block SHALL have port done, output, NUM_REQ bits: one-cycle end-of-grant pulse to the granted requester.
REQ-015 The block SHALL have port busy, output, 1 bit: 1 while in BURST.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and BURST.
REQ-017 In IDLE with req nonzero, the block SHALL select the first set req bit searching upward from rr_ptr with wrap, register the one-hot grant, clear the word count and enter BURST on the next edge.
REQ-018 In IDLE with req all-zero, the block SHALL hold grant=0 and remain in IDLE.
REQ-019 In BURST, a transfer SHALL occur in a cycle where fifo_valid=1, cons_ready[g]=1 and req[g]=1; g is the granted index.
REQ-020 fifo_rd SHALL be 1 exactly in transfer cycles, and 0 in IDLE and whenever fifo_valid=0, so the block never pops an empty FIFO.
REQ-021 out_data SHALL equal fifo_data combinationally, and out_valid[g] SHALL equal fifo_rd; all other out_valid bits SHALL be 0.
REQ-022 The 8-bit word count SHALL increment on each transfer.
REQ-023 A grant SHALL end on the transfer where count = BURST_LEN-1, or in any BURST cycle where req[g]=0 (abort; no transfer that cycle).
REQ-024 When a grant ends, the block SHALL pulse done[g]=1 for that cycle, set rr_ptr to (g+1) mod NUM_REQ, clear grant and return to IDLE on the next edge.
REQ-025 A grant end SHALL give exactly one IDLE cycle, with grant=0, before the next grant.
REQ-026 FIFO stalls (fifo_valid=0) or consumer stalls (cons_ready[g]=0) SHALL hold the count and the grant indefinitely with no timeout.
REQ-027 Changes on req of non-granted requesters SHALL not affect the current grant.
REQ-028 grant SHALL never have more than one bit set.
REQ-029 busy SHALL be 1 exactly when state = BURST.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, grant=0, count=0, rr_ptr=0, done=0 and busy=0.
REQ-031 While rst_n=0, fifo_rd and out_valid SHALL be 0 regardless of other inputs.
REQ-032 Reset asserted mid-burst SHALL abandon the burst without a done pulse.
REQ-033 After rst_n rises, the first arbitration SHALL favour requester 0.

Verification
REQ-034 The bench SHALL cover: after reset, req=0001, fifo_valid=1, cons_ready=all-1 -> grant=0001 one cycle later, 8 consecutive fifo_rd pulses, done[0] on the 8th, then grant=0 for one cycle.
REQ-035 The bench SHALL cover: req=1111 held, FIFO always valid -> grants 0001, 0010, 0100, 1000, 0001 in order, each exactly 8 words, with one idle cycle between grants.
REQ-036 The bench SHALL cover: grant to requester 1, fifo_valid dropped after 3 words for 5 cycles -> fifo_rd=0 during the gap, count holds, burst completes with 8 words total.
REQ-037 The bench SHALL cover: grant to requester 2, req[2] dropped after 4 words -> no transfer in the drop cycle, done[2] pulses, the next grant starts search at requester 3.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-burst after 5 words -> grant, fifo_rd and done go 0 immediately, and the next grant goes to requester 0.
REQ-039 The bench SHALL cover: BURST_LEN=1, req=0011 -> grants alternate 0001/0010, each with one word and one done pulse.
